afifo_wr_stim: RTL and testbench

- Synthesizable write-side stimulus engine for the async FIFO; drives the FIFO write port (winc/wdata) under wfull backpressure in the wclk domain.
- Accepts one write command at a time and returns one response per command.
- Supports a retry/timeout policy on wfull and deliberate overflow injection.
- Used in FPGA/emulation benches, mirroring the read-side driver behaviour for the write end.

---
 rtl/afifo_wr_stim_if.sv | 30 +++
 rtl/afifo_wr_stim.sv | 152 +++++++++++++++
 tb/tb_afifo_wr_stim.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_wr_stim_if.sv
// Command/response, FIFO write-port and counter signals of the async FIFO write-side stimulus engine.
// master = the engine, slave = whatever issues commands and models the FIFO.
interface afifo_wr_stim_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RETRY_W    = 5,
  parameter int CNT_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_ovf;
  logic                  wfull;
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_status;
  logic [RETRY_W-1:0]    rsp_retry;
  logic [CNT_WIDTH-1:0]  wr_count;

  modport master (
    input  cmd_valid, cmd_data, cmd_ovf, wfull, rsp_ready,
    output cmd_ready, winc, wdata, rsp_valid, rsp_status, rsp_retry, wr_count
  );

  modport slave (
    output cmd_valid, cmd_data, cmd_ovf, wfull, rsp_ready,
    input  cmd_ready, winc, wdata, rsp_valid, rsp_status, rsp_retry, wr_count
  );
endinterface

// File: rtl/afifo_wr_stim.sv
// Write-side FIFO stimulus engine: one command in flight, winc two edges after accept (one for overflow
// injection), response held until rsp_ready; wfull stalls the write and times out after MAX_FULL_RETRY samples.
module afifo_wr_stim #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_FULL_RETRY = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int RETRY_W        = $clog2(MAX_FULL_RETRY + 1)
) (
  input logic            wclk,
  input logic            wrst_n,
  afifo_wr_stim_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0]         WR_OK       = 2'b00;
  localparam logic [1:0]         WR_TIMEOUT  = 2'b01;
  localparam logic [1:0]         WR_OVERFLOW = 2'b10;
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_FULL_RETRY);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT   = {CNT_WIDTH{1'b1}};

  state_t                state_q,      state_d;
  logic [DATA_WIDTH-1:0] data_q,       data_d;
  logic                  ovf_q,        ovf_d;
  logic [RETRY_W-1:0]    retry_q,      retry_d;
  logic                  winc_q,       winc_d;
  logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic                  cmd_ready_q,  cmd_ready_d;
  logic                  rsp_valid_q,  rsp_valid_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [RETRY_W-1:0]    rsp_retry_q,  rsp_retry_d;
  logic [CNT_WIDTH-1:0]  wr_count_q,   wr_count_d;

  logic [RETRY_W-1:0]    retry_inc;
  logic                  accept;

  assign retry_inc = retry_q + RETRY_W'(1);
  // cmd_ready is low for the first cycle after reset release, so IDLE alone is not enough to accept.
  assign accept    = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      ovf_q        <= 1'b0;
      retry_q      <= '0;
      winc_q       <= 1'b0;
      wdata_q      <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= WR_OK;
      rsp_retry_q  <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      ovf_q        <= ovf_d;
      retry_q      <= retry_d;
      winc_q       <= winc_d;
      wdata_q      <= wdata_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_retry_q  <= rsp_retry_d;
      wr_count_q   <= wr_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    ovf_d        = ovf_q;
    retry_d      = retry_q;
    winc_d       = 1'b0;
    wdata_d      = wdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_retry_d  = rsp_retry_q;
    wr_count_d   = wr_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = bus.cmd_data;
          ovf_d   = bus.cmd_ovf;
          retry_d = '0;
          if (bus.cmd_ovf) begin
            // Injection skips the wfull check entirely and writes on the accepting edge.
            winc_d  = 1'b1;
            wdata_d = bus.cmd_data;
            state_d = WRITE;
          end else begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (!bus.wfull) begin
          winc_d  = 1'b1;
          wdata_d = data_q;
          state_d = WRITE;
        end else begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_MAX) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = WR_TIMEOUT;
            rsp_retry_d  = retry_inc;
          end
        end
      end

      WRITE: begin
        if (wr_count_q != CNT_SAT) begin
          wr_count_d = wr_count_q + CNT_WIDTH'(1);
        end
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_status_d = ovf_q ? WR_OVERFLOW : WR_OK;
        rsp_retry_d  = retry_q;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.winc       = winc_q;
  assign bus.wdata      = wdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_retry  = rsp_retry_q;
  assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_afifo_wr_stim.sv
// Directed bench for afifo_wr_stim: reset, normal write, wfull retry, timeout, overflow, response hold,
// back-to-back overflow commands and reset during a write.
module tb_afifo_wr_stim;

  logic wclk = 1'b0;
  logic wrst_n;
  int   checks = 0;
  int   errors = 0;

  afifo_wr_stim_if #(.DATA_WIDTH(8), .RETRY_W(5), .CNT_WIDTH(16)) bus ();

  afifo_wr_stim #(
    .DATA_WIDTH    (8),
    .MAX_FULL_RETRY(16),
    .CNT_WIDTH     (16),
    .RETRY_W       (5)
  ) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus)
  );

  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Presents a command and returns 1 ns after the accepting edge with cmd_valid dropped.
  task automatic send_cmd(input logic [7:0] d, input logic ovf);
    int n = 0;
    bus.cmd_data  = d;
    bus.cmd_ovf   = ovf;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1 within 20 cycles", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_ovf   = 1'b0;
  endtask

  task automatic test_reset();
    wrst_n        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.cmd_ovf   = 1'b0;
    bus.wfull     = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.winc, bus.cmd_ready, bus.rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: winc/cmd_ready/rsp_valid=%b required 000",
               {bus.winc, bus.cmd_ready, bus.rsp_valid});
    end
    checks++;
    if ({bus.rsp_status, bus.rsp_retry, bus.wdata, bus.wr_count} !== 31'd0) begin
      errors++;
      $display("FAIL reset_data: status=%0d retry=%0d wdata=%h count=%0d required all 0",
               bus.rsp_status, bus.rsp_retry, bus.wdata, bus.wr_count);
    end
    bus.cmd_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.winc !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: cmd_ready=%b winc=%b required 0 0", bus.cmd_ready, bus.winc);
    end
    bus.cmd_valid = 1'b0;
    wrst_n = 1'b1;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_normal();
    bus.wfull     = 1'b0;
    bus.rsp_ready = 1'b1;
    send_cmd(8'hA5, 1'b0);
    checks++;
    if (bus.winc !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL normal_e0: winc=%b cmd_ready=%b required 0 0", bus.winc, bus.cmd_ready);
    end
    tick();
    checks++;
    if (bus.winc !== 1'b1 || bus.wdata !== 8'hA5) begin
      errors++;
      $display("FAIL normal_winc: winc=%b wdata=%h required 1 a5", bus.winc, bus.wdata);
    end
    tick();
    checks++;
    if (bus.winc !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00 ||
        bus.rsp_retry !== 5'd0 || bus.wr_count !== 16'd1) begin
      errors++;
      $display("FAIL normal_rsp: winc=%b rsp_valid=%b status=%0d retry=%0d count=%0d required 0 1 0 0 1",
               bus.winc, bus.rsp_valid, bus.rsp_status, bus.rsp_retry, bus.wr_count);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wdata !== 8'hA5) begin
      errors++;
      $display("FAIL normal_done: rsp_valid=%b cmd_ready=%b wdata=%h required 0 1 a5",
               bus.rsp_valid, bus.cmd_ready, bus.wdata);
    end
  endtask

  task automatic test_retry();
    logic bad = 1'b0;
    bus.wfull = 1'b1;
    send_cmd(8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.winc !== 1'b0 || bus.rsp_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL retry_stall: winc or rsp_valid seen during wfull, required none");
    end
    bus.wfull = 1'b0;
    tick();
    checks++;
    if (bus.winc !== 1'b1 || bus.wdata !== 8'h3C) begin
      errors++;
      $display("FAIL retry_winc: winc=%b wdata=%h required 1 3c", bus.winc, bus.wdata);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00 || bus.rsp_retry !== 5'd3 ||
        bus.wr_count !== 16'd2) begin
      errors++;
      $display("FAIL retry_rsp: rsp_valid=%b status=%0d retry=%0d count=%0d required 1 0 3 2",
               bus.rsp_valid, bus.rsp_status, bus.rsp_retry, bus.wr_count);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic bad = 1'b0;
    bus.wfull = 1'b1;
    send_cmd(8'h11, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.winc !== 1'b0 || bus.rsp_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: winc or rsp_valid before 16 samples, required none");
    end
    tick();
    checks++;
    if (bus.winc !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b01 ||
        bus.rsp_retry !== 5'd16 || bus.wr_count !== 16'd2) begin
      errors++;
      $display("FAIL timeout_rsp: winc=%b rsp_valid=%b status=%0d retry=%0d count=%0d required 0 1 1 16 2",
               bus.winc, bus.rsp_valid, bus.rsp_status, bus.rsp_retry, bus.wr_count);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wdata !== 8'h3C) begin
      errors++;
      $display("FAIL timeout_done: rsp_valid=%b cmd_ready=%b wdata=%h required 0 1 3c",
               bus.rsp_valid, bus.cmd_ready, bus.wdata);
    end
  endtask

  task automatic test_overflow();
    bus.wfull = 1'b1;
    send_cmd(8'hFF, 1'b1);
    checks++;
    if (bus.winc !== 1'b1 || bus.wdata !== 8'hFF) begin
      errors++;
      $display("FAIL ovf_winc: winc=%b wdata=%h required 1 ff", bus.winc, bus.wdata);
    end
    tick();
    checks++;
    if (bus.winc !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b10 ||
        bus.rsp_retry !== 5'd0 || bus.wr_count !== 16'd3) begin
      errors++;
      $display("FAIL ovf_rsp: winc=%b rsp_valid=%b status=%0d retry=%0d count=%0d required 0 1 2 0 3",
               bus.winc, bus.rsp_valid, bus.rsp_status, bus.rsp_retry, bus.wr_count);
    end
    tick();
    bus.wfull = 1'b0;
  endtask

  task automatic test_rsp_hold();
    bus.wfull     = 1'b0;
    bus.rsp_ready = 1'b0;
    send_cmd(8'h5A, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00 || bus.rsp_retry !== 5'd0 ||
          bus.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: rsp_valid=%b status=%0d retry=%0d cmd_ready=%b required 1 0 0 0",
                 i, bus.rsp_valid, bus.rsp_status, bus.rsp_retry, bus.cmd_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wr_count !== 16'd4) begin
      errors++;
      $display("FAIL hold_release: rsp_valid=%b cmd_ready=%b count=%0d required 0 1 4",
               bus.rsp_valid, bus.cmd_ready, bus.wr_count);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [8:0] pattern = '0;
    bus.rsp_ready = 1'b1;
    bus.wfull     = 1'b1;
    bus.cmd_data  = 8'hC3;
    bus.cmd_ovf   = 1'b1;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      pattern[i] = bus.winc;
      if (bus.winc === 1'b1) pulses++;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_ovf   = 1'b0;
    bus.wfull     = 1'b0;
    checks++;
    if (pattern !== 9'b001001001 || pulses != 3) begin
      errors++;
      $display("FAIL b2b_spacing: winc pattern=%b required 001001001", pattern);
    end
    tick();
    checks++;
    if (bus.wr_count !== 16'd7 || bus.winc !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: count=%0d winc=%b cmd_ready=%b required 7 0 1",
               bus.wr_count, bus.winc, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic bad = 1'b0;
    bus.wfull     = 1'b0;
    bus.rsp_ready = 1'b1;
    send_cmd(8'h77, 1'b0);
    tick();
    checks++;
    if (bus.winc !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: winc=%b required 1", bus.winc);
    end
    #2 wrst_n = 1'b0;
    #1;
    checks++;
    if (bus.winc !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.wr_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_async: winc=%b rsp_valid=%b count=%0d required 0 0 0",
               bus.winc, bus.rsp_valid, bus.wr_count);
    end
    tick();
    tick();
    wrst_n = 1'b1;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: cmd_ready=%b rsp_valid=%b required 1 0",
               bus.cmd_ready, bus.rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.winc !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || bus.wr_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_drop: stray activity=%b count=%0d required 0 0", bad, bus.wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_retry();
    test_timeout();
    test_overflow();
    test_rsp_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
